vga_scan_mixer: RTL and testbench

//   Scan-side counterpart of the sprite widgets. Generates 800x600@72 Hz VGA timing, drives X/Y to

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_axis_counter.sv | 36 +++
 rtl/vga_scan_mixer.sv | 94 +++++++++
 tb/tb_vga_scan_mixer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants for the 800x600@72 Hz VGA scan and the shared pixel/count types.
// Widgets and the scan mixer import this package for their types and defaults.
package vga_timing_pkg;

    localparam int H_VISIBLE = 800;
    localparam int H_FRONT   = 56;
    localparam int H_SYNC    = 120;
    localparam int H_BACK    = 64;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 600;
    localparam int V_FRONT   = 37;
    localparam int V_SYNC    = 6;
    localparam int V_BACK    = 23;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic SYNC_POL = 1'b1;

    localparam int RGB_W = 12;
    localparam int CNT_W = 11;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: counts 0..TOTAL-1 on each step, wraps, and decodes the
// active region and the sync-pulse window from the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = 800,
    parameter int FRONT   = 56,
    parameter int SYNC    = 120,
    parameter int TOTAL   = 1040
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   step,
    output count_t count,
    output logic   active,
    output logic   sync_zone
);

    localparam count_t LAST       = count_t'(TOTAL - 1);
    localparam count_t VIS_END    = count_t'(VISIBLE);
    localparam count_t SYNC_START = count_t'(VISIBLE + FRONT);
    localparam count_t SYNC_END   = count_t'(VISIBLE + FRONT + SYNC);

    // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (step) begin
            count <= (count == LAST) ? '0 : count + count_t'(1);
        end
    end

    assign active    = (count < VIS_END);
    assign sync_zone = (count >= SYNC_START) && (count < SYNC_END);

endmodule

// File: rtl/vga_scan_mixer.sv
// VGA scan generator plus registered two-widget priority mixer and per-frame widget tick.
// Define VGA_BORDER_EN to force a white 1-pixel frame around the active area.
module vga_scan_mixer
    import vga_timing_pkg::count_t, vga_timing_pkg::rgb_t;
#(
    parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK    = vga_timing_pkg::H_BACK,
    parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK    = vga_timing_pkg::V_BACK,
    parameter logic SYNC_POL  = vga_timing_pkg::SYNC_POL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        aYes,
    input  logic [11:0] aRGB,
    input  logic        bYes,
    input  logic [11:0] bRGB,
    input  logic [11:0] bgRGB,
    output logic [10:0] X,
    output logic [10:0] Y,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        videoOn,
    output logic        frameTick
);

    localparam int     H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int     V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam count_t H_LAST     = count_t'(H_TOTAL - 1);
    localparam count_t V_LAST_VIS = count_t'(V_VISIBLE - 1);

    logic   h_wrap;
    logic   h_active, v_active, active;
    logic   h_sync_zone, v_sync_zone;
    rgb_t   rgb_next, rgb_q;

    assign h_wrap = (X == H_LAST);

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .TOTAL(H_TOTAL)
    ) u_h_counter (
        .clk(clk), .reset(reset), .step(1'b1),
        .count(X), .active(h_active), .sync_zone(h_sync_zone)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .TOTAL(V_TOTAL)
    ) u_v_counter (
        .clk(clk), .reset(reset), .step(h_wrap),
        .count(Y), .active(v_active), .sync_zone(v_sync_zone)
    );

    assign active = h_active && v_active;

    // Widget yes flags only matter inside the visible area; A outranks B.
    always_comb begin
        rgb_next = '0;
        if (active) begin
            if (aYes)      rgb_next = aRGB;
            else if (bYes) rgb_next = bRGB;
            else           rgb_next = bgRGB;
        end
`ifdef VGA_BORDER_EN
        if (active && (X == '0 || X == count_t'(H_VISIBLE - 1) || Y == '0 || Y == V_LAST_VIS))
            rgb_next = 12'hFFF;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q     <= '0;
            videoOn   <= 1'b0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            frameTick <= 1'b0;
        end else begin
            rgb_q     <= rgb_next;
            videoOn   <= active;
            hsync     <= h_sync_zone ? SYNC_POL : ~SYNC_POL;
            vsync     <= v_sync_zone ? SYNC_POL : ~SYNC_POL;
            frameTick <= h_wrap && (Y == V_LAST_VIS);
        end
    end

    assign {red, green, blue} = rgb_q;

endmodule

// File: tb/tb_vga_scan_mixer.sv
// Self-checking bench for vga_scan_mixer: full horizontal timing, shortened vertical
// timing (12 lines per frame) so whole frames are covered in a short run.
module tb_vga_scan_mixer;

    localparam int HV = 800, HF = 56, HS = 120, HB = 64, HT = HV + HF + HS + HB;
    localparam int VV = 6, VF = 2, VS = 2, VB = 2, VT = VV + VF + VS + VB;
`ifdef VGA_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        aYes, bYes;
    logic [11:0] aRGB, bRGB, bgRGB;
    logic [10:0] X, Y;
    logic        hsync, vsync, videoOn, frameTick;
    logic [3:0]  red, green, blue;
    wire  [11:0] rgb = {red, green, blue};

    vga_scan_mixer #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset),
        .aYes(aYes), .aRGB(aRGB), .bYes(bYes), .bRGB(bRGB), .bgRGB(bgRGB),
        .X(X), .Y(Y), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .videoOn(videoOn), .frameTick(frameTick)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int x, input int y, input string name);
        int n = 0;
        while (!(X == x && Y == y) && n < 2 * HT * VT) begin
            tick();
            n++;
        end
        check({name, " reach"}, {10'd0, X, Y}, {10'd0, x[10:0], y[10:0]});
    endtask

    function automatic logic [11:0] exp_pix(input int x, input int y, input logic [11:0] base);
        bit on_border = (x < HV) && (y < VV) && (x == 0 || x == HV - 1 || y == 0 || y == VV - 1);
        return (BORDER && on_border) ? 12'hFFF : base;
    endfunction

    typedef struct {
        int          x;
        int          y;
        logic        a_yes;
        logic [11:0] a_rgb;
        logic        b_yes;
        logic [11:0] b_rgb;
        logic [11:0] bg;
        logic [11:0] exp_rgb;
        logic        exp_von;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int px, py, exp_x, exp_y;
        int pos_err, von_err, rgb_err, hs_err, vs_err, ft_err;
        int hs_cnt, vs_cnt, ticks, tick_x, tick_y;
        logic act;

        vecs[0] = '{10,  1, 1'b1, 12'hF00, 1'b1, 12'h0F0, 12'h00F, 12'hF00, 1'b1};
        vecs[1] = '{11,  1, 1'b0, 12'hF00, 1'b1, 12'h0F0, 12'h00F, 12'h0F0, 1'b1};
        vecs[2] = '{12,  1, 1'b0, 12'hF00, 1'b0, 12'h0F0, 12'h00F, 12'h00F, 1'b1};
        vecs[3] = '{799, 1, 1'b0, 12'hF00, 1'b1, 12'h0F0, 12'h00F, 12'h0F0, 1'b1};
        vecs[4] = '{800, 1, 1'b1, 12'hFFF, 1'b0, 12'h0F0, 12'h00F, 12'h000, 1'b0};
        vecs[5] = '{900, 1, 1'b1, 12'hFFF, 1'b1, 12'h0F0, 12'h00F, 12'h000, 1'b0};
        vecs[6] = '{0,   2, 1'b0, 12'hF00, 1'b0, 12'h0F0, 12'h123, 12'h123, 1'b1};
        vecs[7] = '{1,   3, 1'b0, 12'hF00, 1'b1, 12'hABC, 12'h111, 12'hABC, 1'b1};
        vecs[8] = '{0,   5, 1'b0, 12'hF00, 1'b0, 12'h0F0, 12'h0A5, 12'h0A5, 1'b1};
        vecs[9] = '{5,   6, 1'b1, 12'hFFF, 1'b0, 12'h0F0, 12'h00F, 12'h000, 1'b0};

        reset = 1'b1;
        aYes = 1'b0; bYes = 1'b0;
        aRGB = 12'h000; bRGB = 12'h000; bgRGB = 12'h5A3;
        repeat (3) tick();
        check("reset X", {21'd0, X}, 32'd0);
        check("reset Y", {21'd0, Y}, 32'd0);
        check("reset rgb", {20'd0, rgb}, 32'd0);
        check("reset hsync", {31'd0, hsync}, 32'd0);
        check("reset vsync", {31'd0, vsync}, 32'd0);
        check("reset videoOn", {31'd0, videoOn}, 32'd0);
        check("reset frameTick", {31'd0, frameTick}, 32'd0);
        reset = 1'b0;

        // One full frame from reset, every cycle compared against the raster model.
        pos_err = 0; von_err = 0; rgb_err = 0; hs_err = 0; vs_err = 0; ft_err = 0;
        hs_cnt = 0; vs_cnt = 0; ticks = 0; tick_x = -1; tick_y = -1;
        for (int i = 0; i < HT * VT; i++) begin
            px = int'(X); py = int'(Y);
            tick();
            exp_x = (px == HT - 1) ? 0 : px + 1;
            exp_y = (px == HT - 1) ? ((py == VT - 1) ? 0 : py + 1) : py;
            act = (px < HV) && (py < VV);
            if (X != exp_x || Y != exp_y) pos_err++;
            if (videoOn != act) von_err++;
            if (rgb != exp_pix(px, py, act ? 12'h5A3 : 12'h000)) rgb_err++;
            if (hsync != (px >= 856 && px < 976)) hs_err++;
            if (vsync != (py >= VV + VF && py < VV + VF + VS)) vs_err++;
            if (frameTick != (px == HT - 1 && py == VV - 1)) ft_err++;
            if (hsync) hs_cnt++;
            if (vsync) vs_cnt++;
            if (frameTick) begin
                ticks++;
                tick_x = int'(X);
                tick_y = int'(Y);
            end
        end
        check("frame X/Y sequence errors", pos_err, 0);
        check("frame videoOn errors", von_err, 0);
        check("frame rgb errors", rgb_err, 0);
        check("frame hsync window errors", hs_err, 0);
        check("frame vsync window errors", vs_err, 0);
        check("frame frameTick errors", ft_err, 0);
        check("hsync cycles per frame", hs_cnt, HS * VT);
        check("vsync cycles per frame", vs_cnt, VS * HT);
        check("frameTick pulses per frame", ticks, 1);
        check("frameTick at X", tick_x, 0);
        check("frameTick at Y", tick_y, VV);
        check("frame length returns X/Y to 0", {10'd0, X, Y}, 32'd0);

        foreach (vecs[i]) begin
            goto(vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));
            aYes = vecs[i].a_yes; aRGB = vecs[i].a_rgb;
            bYes = vecs[i].b_yes; bRGB = vecs[i].b_rgb;
            bgRGB = vecs[i].bg;
            tick();
            check($sformatf("vec%0d rgb", i), {20'd0, rgb},
                  {20'd0, exp_pix(vecs[i].x, vecs[i].y, vecs[i].exp_rgb)});
            check($sformatf("vec%0d videoOn", i), {31'd0, videoOn}, {31'd0, vecs[i].exp_von});
        end
        aYes = 1'b0; bYes = 1'b0; bgRGB = 12'h5A3;

        goto(HT - 1, 7, "line wrap");
        tick();
        check("line wrap X/Y", {10'd0, X, Y}, {21'd0, 11'd8});
        goto(HT - 1, VT - 1, "frame wrap");
        tick();
        check("frame wrap X/Y", {10'd0, X, Y}, 32'd0);

        goto(900, 2, "hsync reset");
        check("hsync before reset", {31'd0, hsync}, 32'd1);
        reset = 1'b1;
        tick();
        check("hsync after reset", {31'd0, hsync}, 32'd0);
        reset = 1'b0;

        goto(400, 3, "mid-frame reset");
        check("rgb before mid reset", {20'd0, rgb}, {20'd0, exp_pix(399, 3, 12'h5A3)});
        reset = 1'b1;
        tick();
        check("mid reset first clk X/Y", {10'd0, X, Y}, 32'd0);
        repeat (2) tick();
        check("mid reset X/Y", {10'd0, X, Y}, 32'd0);
        check("mid reset rgb", {20'd0, rgb}, 32'd0);
        check("mid reset syncs", {30'd0, hsync, vsync}, 32'd0);
        check("mid reset frameTick", {31'd0, frameTick}, 32'd0);
        reset = 1'b0;
        tick();
        check("restart after reset X/Y", {10'd0, X, Y}, {10'd1, 11'd0});

        goto(HT - 1, VV - 1, "reset at tick point");
        reset = 1'b1;
        tick();
        check("no frameTick under reset", {31'd0, frameTick}, 32'd0);
        check("reset at tick point X/Y", {10'd0, X, Y}, 32'd0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
